// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter in front of a single-port synchronous RAM
//
// Port 0 (CPU memory stage) and port 1 (loader/DMA) share one RAM. Grants are
// combinational and the access goes out to the RAM in the grant cycle. A port
// that asserts lockN with its granted request keeps ownership for a burst of
// up to MAX_BURST consecutive grants.
//
// Build option: define MEM_ARB_RR_EN for round-robin contention in IDLE;
// otherwise port 0 has fixed priority.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req0/1, we0/1, lock0/1   per-port request, write enable, burst lock
//   addr0/1, wdata0/1        per-port address and write data
//   gnt0/1                   combinational grant
//   rvalid0/1                registered read-data-valid per port
//   rdata                    shared read data (ram_q)
//   ram_addr, ram_wdata,
//   ram_wren, ram_q          RAM command and read data
//   busy                     a port currently owns the RAM
module mem_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  state_t     state;
  logic [7:0] burst_cnt;

`ifdef MEM_ARB_RR_EN
  logic last_gnt;  // index of the most recently granted port
`endif

  // Grant decode. Held low throughout reset regardless of requests.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req0 && req1) begin
`ifdef MEM_ARB_RR_EN
            // Favour whichever port did not win last time.
            if (last_gnt) gnt0 = 1'b1;
            else          gnt1 = 1'b1;
`else
            gnt0 = 1'b1;
`endif
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
        OWN0:    gnt0 = req0;
        OWN1:    gnt1 = req1;
        default: ;
      endcase
    end
  end

  // RAM command mux; everything is zero when nobody is granted.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wren  = 1'b0;
    if (gnt0) begin
      ram_addr  = addr0;
      ram_wdata = wdata0;
      ram_wren  = we0;
    end else if (gnt1) begin
      ram_addr  = addr1;
      ram_wdata = wdata1;
      ram_wren  = we1;
    end
  end

  assign rdata = ram_q;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= 8'd0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_gnt  <= 1'b1;
`endif
    end else begin
      // RAM returns data one cycle after a read is issued.
      rvalid0 <= gnt0 && !we0;
      rvalid1 <= gnt1 && !we1;
`ifdef MEM_ARB_RR_EN
      if (gnt0)      last_gnt <= 1'b0;
      else if (gnt1) last_gnt <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (gnt0 && lock0) begin
            state     <= OWN0;
            burst_cnt <= 8'd1;
          end else if (gnt1 && lock1) begin
            state     <= OWN1;
            burst_cnt <= 8'd1;
          end
        end
        OWN0: begin
          // Reaching the burst limit ends ownership even with lock held.
          if ((gnt0 && (burst_cnt + 8'd1 == BURST_MAX)) || !lock0) begin
            state     <= IDLE;
            burst_cnt <= 8'd0;
          end else if (gnt0) begin
            burst_cnt <= burst_cnt + 8'd1;
          end
        end
        OWN1: begin
          if ((gnt1 && (burst_cnt + 8'd1 == BURST_MAX)) || !lock1) begin
            state     <= IDLE;
            burst_cnt <= 8'd0;
          end else if (gnt1) begin
            burst_cnt <= burst_cnt + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          burst_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule
